// File: rtl/i2c_defs.sv
// Shared I2C definitions: framer state encodings, byte/ACK constants
// and the default stuck-bus timeout.
package i2c_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int          I2C_BYTE_W      = 8;
    localparam logic        I2C_ACK         = 1'b0;
    localparam logic [15:0] I2C_TIMEOUT_DEF = 16'd50000;

endpackage

// File: rtl/i2c_bit_framer_if.sv
// Bundle between the I2C input filter, the bit framer and the slave
// protocol FSM; master is the framer side, slave the consumer side.
interface i2c_bit_framer_if;
    import i2c_defs::*;

    logic                  sda_filt_i;
    logic                  scl_filt_i;
    logic                  start_o;
    logic                  rep_start_o;
    logic                  stop_o;
    logic                  scl_rise_o;
    logic                  scl_fall_o;
    logic [I2C_BYTE_W-1:0] byte_o;
    logic                  byte_valid_o;
    logic                  ack_slot_o;
    logic                  ack_bit_o;
    logic                  ack_valid_o;
    logic [3:0]            bit_cnt_o;
    logic                  bus_busy_o;
    logic                  timeout_o;

    modport master (
        input  sda_filt_i, scl_filt_i,
        output start_o, rep_start_o, stop_o,
        output scl_rise_o, scl_fall_o,
        output byte_o, byte_valid_o,
        output ack_slot_o, ack_bit_o, ack_valid_o,
        output bit_cnt_o, bus_busy_o, timeout_o
    );

    modport slave (
        output sda_filt_i, scl_filt_i,
        input  start_o, rep_start_o, stop_o,
        input  scl_rise_o, scl_fall_o,
        input  byte_o, byte_valid_o,
        input  ack_slot_o, ack_bit_o, ack_valid_o,
        input  bit_cnt_o, bus_busy_o, timeout_o
    );

endinterface

// File: rtl/i2c_bus_cond_detect.sv
// Bus condition detector: keeps the previous SDA/SCL levels and flags
// START, STOP and SCL edges combinationally for the framer to register.
module i2c_bus_cond_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sda_i,
    input  logic scl_i,
    output logic start_o,
    output logic stop_o,
    output logic rise_o,
    output logic fall_o
);

    logic sda_q;
    logic scl_q;

    // Input history; idle bus is high so a released bus shows no edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sda_q <= 1'b1;
            scl_q <= 1'b1;
        end else begin
            sda_q <= sda_i;
            scl_q <= scl_i;
        end
    end

    // SDA moves only count as START/STOP while SCL is steadily high,
    // so a simultaneous SCL+SDA change is an SCL edge only.
    assign start_o = scl_q & scl_i & sda_q & ~sda_i;
    assign stop_o  = scl_q & scl_i & ~sda_q & sda_i;
    assign rise_o  = ~scl_q & scl_i;
    assign fall_o  = scl_q & ~scl_i;

endmodule

// File: rtl/i2c_bit_framer.sv
// I2C bit framer: turns filtered SDA/SCL into START/STOP, byte and ACK
// strobes for the slave protocol FSM, with a stuck-bus timeout.
module i2c_bit_framer
    import i2c_defs::*;
#(
    parameter int                   TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC =
        TIMEOUT_W'(I2C_TIMEOUT_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    i2c_bit_framer_if.master  bus
);

    localparam logic TMO_EN = (TIMEOUT_CYC != '0);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST =
        TIMEOUT_CYC - TIMEOUT_W'(1);

    logic start_e, stop_e, rise_e, fall_e;
    logic any_e, tmo_hit;

    state_e                state_q;
    logic [I2C_BYTE_W-1:0] shreg_q, byte_q, shift_w;
    logic [3:0]            bit_cnt_q;
    logic [TIMEOUT_W-1:0]  tmo_q;
    logic start_q, rep_q, stop_q, rise_q, fall_q;
    logic bvalid_q, slot_q, ackb_q, ackv_q;
    logic busy_q, tmo_pulse_q;

    i2c_bus_cond_detect u_cond (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sda_i   (bus.sda_filt_i),
        .scl_i   (bus.scl_filt_i),
        .start_o (start_e),
        .stop_o  (stop_e),
        .rise_o  (rise_e),
        .fall_o  (fall_e)
    );

    assign shift_w = {shreg_q[I2C_BYTE_W-2:0], bus.sda_filt_i};
    assign any_e   = start_e | stop_e | rise_e | fall_e;
    assign tmo_hit = TMO_EN & busy_q & ~any_e & (tmo_q == TMO_LAST);

    // Stuck-bus counter: runs only while busy, saturates instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i || !TMO_EN || !busy_q || any_e) begin
            tmo_q <= '0;
        end else if (tmo_q != '1) begin
            tmo_q <= tmo_q + TIMEOUT_W'(1);
        end
    end

    // Framing FSM with registered strobes; START/STOP/timeout win over bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            byte_q      <= '0;
            bit_cnt_q   <= '0;
            start_q     <= 1'b0;
            rep_q       <= 1'b0;
            stop_q      <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            bvalid_q    <= 1'b0;
            slot_q      <= 1'b0;
            ackb_q      <= 1'b0;
            ackv_q      <= 1'b0;
            busy_q      <= 1'b0;
            tmo_pulse_q <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            rep_q       <= 1'b0;
            stop_q      <= 1'b0;
            bvalid_q    <= 1'b0;
            ackv_q      <= 1'b0;
            tmo_pulse_q <= 1'b0;
            rise_q      <= rise_e;
            fall_q      <= fall_e;
            if (start_e) begin
                state_q   <= ST_DATA;
                shreg_q   <= '0;
                bit_cnt_q <= '0;
                slot_q    <= 1'b0;
                busy_q    <= 1'b1;
                start_q   <= 1'b1;
                rep_q     <= busy_q;
            end else if (stop_e || tmo_hit) begin
                state_q     <= ST_IDLE;
                bit_cnt_q   <= '0;
                slot_q      <= 1'b0;
                busy_q      <= 1'b0;
                stop_q      <= stop_e;
                tmo_pulse_q <= tmo_hit;
            end else begin
                unique case (state_q)
                    ST_DATA: begin
                        if (rise_e && bit_cnt_q < 4'd8) begin
                            shreg_q   <= shift_w;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                byte_q   <= shift_w;
                                bvalid_q <= 1'b1;
                            end
                        end else if (fall_e && bit_cnt_q == 4'd8) begin
                            state_q <= ST_ACK;
                            slot_q  <= 1'b1;
                        end
                    end
                    ST_ACK: begin
                        if (rise_e) begin
                            ackb_q <= bus.sda_filt_i;
                            ackv_q <= 1'b1;
                        end else if (fall_e) begin
                            state_q   <= ST_DATA;
                            slot_q    <= 1'b0;
                            bit_cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.start_o      = start_q;
    assign bus.rep_start_o  = rep_q;
    assign bus.stop_o       = stop_q;
    assign bus.scl_rise_o   = rise_q;
    assign bus.scl_fall_o   = fall_q;
    assign bus.byte_o       = byte_q;
    assign bus.byte_valid_o = bvalid_q;
    assign bus.ack_slot_o   = slot_q;
    assign bus.ack_bit_o    = ackb_q;
    assign bus.ack_valid_o  = ackv_q;
    assign bus.bit_cnt_o    = bit_cnt_q;
    assign bus.bus_busy_o   = busy_q;
    assign bus.timeout_o    = tmo_pulse_q;

endmodule

// File: tb/tb_i2c_bit_framer.sv
// Directed bench for i2c_bit_framer: drives I2C frames on the filtered
// lines and checks strobes against a byte/ACK scoreboard.
module tb_i2c_bit_framer;
    import i2c_defs::*;

    localparam int HALF = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    i2c_bit_framer_if bus ();

    i2c_bit_framer #(
        .TIMEOUT_W   (16),
        .TIMEOUT_CYC (16'd20)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;
    int n_start = 0, n_rep = 0, n_stop = 0;
    int n_bv = 0, n_av = 0, n_tmo = 0;
    int last_fall = 0, tmo_at = 0;
    int busy_drops = 0;
    bit watch_busy = 1'b0;
    logic [7:0] exp_byte[$];
    logic       exp_ack[$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic tick();
        logic [7:0] eb;
        logic       ea;
        @(posedge clk);
        #1;
        cyc_n++;
        if (bus.start_o)     n_start++;
        if (bus.rep_start_o) n_rep++;
        if (bus.stop_o)      n_stop++;
        if (bus.scl_fall_o)  last_fall = cyc_n;
        if (bus.timeout_o) begin
            n_tmo++;
            tmo_at = cyc_n;
        end
        if (watch_busy && !bus.bus_busy_o) busy_drops++;
        if (bus.byte_valid_o) begin
            n_bv++;
            chk("byte_sb_nonempty", 32'(exp_byte.size() != 0), 1);
            if (exp_byte.size() != 0) begin
                eb = exp_byte.pop_front();
                chk("byte_val", 32'(bus.byte_o), 32'(eb));
                chk("byte_with_rise", 32'(bus.scl_rise_o), 1);
                chk("slot_at_byte", 32'(bus.ack_slot_o), 0);
            end
        end
        if (bus.ack_valid_o) begin
            n_av++;
            chk("ack_sb_nonempty", 32'(exp_ack.size() != 0), 1);
            if (exp_ack.size() != 0) begin
                ea = exp_ack.pop_front();
                chk("ack_bit", 32'(bus.ack_bit_o), 32'(ea));
                chk("slot_at_ack", 32'(bus.ack_slot_o), 1);
            end
        end
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_lines(input logic scl, input logic sda);
        bus.scl_filt_i = scl;
        bus.sda_filt_i = sda;
        wait_n(HALF);
    endtask

    task automatic i2c_start();
        set_lines(1'b1, 1'b0);
        set_lines(1'b0, 1'b0);
    endtask

    task automatic i2c_rep_start();
        set_lines(1'b0, 1'b1);
        set_lines(1'b1, 1'b1);
        set_lines(1'b1, 1'b0);
        set_lines(1'b0, 1'b0);
    endtask

    task automatic i2c_stop();
        set_lines(1'b0, 1'b0);
        set_lines(1'b1, 1'b0);
        set_lines(1'b1, 1'b1);
    endtask

    task automatic send_bit(input logic b);
        set_lines(1'b0, b);
        set_lines(1'b1, b);
        set_lines(1'b0, b);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        exp_byte.push_back(b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        exp_ack.push_back(ack);
        send_bit(ack);
    endtask

    function automatic logic [22:0] out_vec();
        return {bus.start_o, bus.rep_start_o, bus.stop_o,
                bus.scl_rise_o, bus.scl_fall_o, bus.byte_o,
                bus.byte_valid_o, bus.ack_slot_o, bus.ack_bit_o,
                bus.ack_valid_o, bus.bit_cnt_o, bus.bus_busy_o,
                bus.timeout_o};
    endfunction

    initial begin
        int s0, p0, b0;
        // Reset with the filter outputs low, then release to 1.
        rst = 1'b1;
        bus.scl_filt_i = 1'b0;
        bus.sda_filt_i = 1'b0;
        wait_n(3);
        chk("reset_outputs", 32'(out_vec()), 0);
        rst = 1'b0;
        wait_n(2);
        set_lines(1'b1, 1'b1);
        wait_n(2);
        chk("release_no_start", n_start, 0);
        chk("release_no_stop", n_stop, 0);
        chk("release_busy", 32'(bus.bus_busy_o), 0);
        chk("release_byte", 32'(bus.byte_o), 0);

        // Single byte 0xA5 with ACK, then STOP.
        i2c_start();
        chk("a5_busy", 32'(bus.bus_busy_o), 1);
        send_byte(8'hA5, I2C_ACK);
        chk("a5_slot_end", 32'(bus.ack_slot_o), 0);
        i2c_stop();
        wait_n(2);
        chk("a5_starts", n_start, 1);
        chk("a5_stops", n_stop, 1);
        chk("a5_bytes", n_bv, 1);
        chk("a5_acks", n_av, 1);
        chk("a5_busy_end", 32'(bus.bus_busy_o), 0);
        chk("a5_bitcnt", 32'(bus.bit_cnt_o), 0);

        // 0x3C NACK, repeated START, 0xFF; busy must never drop.
        i2c_start();
        watch_busy = 1'b1;
        send_byte(8'h3C, 1'b1);
        chk("nack_bit", 32'(bus.ack_bit_o), 1);
        i2c_rep_start();
        send_byte(8'hFF, I2C_ACK);
        watch_busy = 1'b0;
        chk("rep_count", n_rep, 1);
        chk("rep_starts", n_start, 3);
        chk("rep_busy_drops", busy_drops, 0);
        chk("rep_byte_last", 32'(bus.byte_o), 32'h0FF);
        i2c_stop();
        wait_n(2);
        chk("rep_stops", n_stop, 2);
        chk("rep_bytes", n_bv, 3);

        // Partial byte discarded by STOP.
        i2c_start();
        for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
        chk("part_bitcnt_mid", 32'(bus.bit_cnt_o), 5);
        i2c_stop();
        wait_n(2);
        chk("part_bytes", n_bv, 3);
        chk("part_bitcnt", 32'(bus.bit_cnt_o), 0);
        chk("part_byte_hold", 32'(bus.byte_o), 32'h0FF);
        chk("part_busy", 32'(bus.bus_busy_o), 0);

        // Stuck bus: START then SCL held low.
        s0 = n_stop;
        i2c_start();
        wait_n(40);
        chk("tmo_count", n_tmo, 1);
        chk("tmo_delay", tmo_at - last_fall, 20);
        chk("tmo_busy", 32'(bus.bus_busy_o), 0);
        chk("tmo_no_stop", n_stop, s0);
        set_lines(1'b0, 1'b1);
        set_lines(1'b1, 1'b1);

        // Simultaneous SCL/SDA toggles mid-byte, then reset.
        s0 = n_stop;
        p0 = n_start;
        b0 = n_bv;
        i2c_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        set_lines(1'b1, 1'b0);
        set_lines(1'b0, 1'b1);
        set_lines(1'b1, 1'b0);
        set_lines(1'b0, 1'b1);
        chk("sim_starts", n_start, p0 + 1);
        chk("sim_stops", n_stop, s0);
        chk("sim_bitcnt", 32'(bus.bit_cnt_o), 5);
        rst = 1'b1;
        bus.scl_filt_i = 1'b1;
        bus.sda_filt_i = 1'b1;
        wait_n(3);
        rst = 1'b0;
        wait_n(3);
        chk("rst_outputs", 32'(out_vec()), 0);
        chk("rst_no_byte", n_bv, b0);
        chk("rst_no_stop", n_stop, s0);
        chk("sb_bytes_left", exp_byte.size(), 0);
        chk("sb_acks_left", exp_ack.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_bit_framer.md
Name: i2c_bit_framer

Overview:
- Sits directly downstream of the I2C SDA/SCL input filter and consumes its filtered SDA/SCL levels.
- Detects START, repeated START and STOP conditions, and SCL rising/falling edges.
- Deserialises 8 data bits MSB-first and flags the 9th (ACK) slot.
- Feeds the I2C slave protocol FSM (address match / register access) with byte and ACK strobes, plus bus-busy and stuck-bus timeout status.

Parameters:
TIMEOUT_W, 16, width of the idle/stuck-bus counter.
TIMEOUT_CYC, 16'd50000, clk_i cycles without any SCL edge while busy before the timeout fires; 0 disables the timeout.

Ports:
clk_i  input  1  system clock; the block's single clock.
rst_i  input  1  synchronous, active-high reset.
sda_filt_i  input  1  filtered SDA from the input filter.
scl_filt_i  input  1  filtered SCL from the input filter.
start_o  output  1  1-cycle pulse on any START condition, including repeated START.
rep_start_o  output  1  1-cycle pulse on a START while bus_busy_o=1.
stop_o  output  1  1-cycle pulse on a STOP condition.
scl_rise_o  output  1  1-cycle pulse on an SCL 0->1 edge.
scl_fall_o  output  1  1-cycle pulse on an SCL 1->0 edge.
byte_o  output  8  last completed byte, MSB first on the wire.
byte_valid_o  output  1  1-cycle pulse when byte_o is updated.
ack_slot_o  output  1  high from the 8th SCL fall to the 9th SCL fall.
ack_bit_o  output  1  SDA sampled at the 9th SCL rise (0 = ACK).
ack_valid_o  output  1  1-cycle pulse when ack_bit_o is updated.
bit_cnt_o  output  4  bits sampled in the current frame, 0..8.
bus_busy_o  output  1  high between START and STOP/timeout.
timeout_o  output  1  1-cycle pulse when the stuck-bus timeout fires.

Behaviour:
- Input history registers: sda_q and scl_q sample the inputs every cycle and reset to 1 (idle bus).
- Event conditions: events compare the current input against its _q register.
  - START = scl_q & scl_filt_i & sda_q & ~sda_filt_i.
  - STOP = scl_q & scl_filt_i & ~sda_q & sda_filt_i.
  - SCL and SDA changing in the same cycle counts as an SCL edge only, never START or STOP.
- Latency: all outputs are registered. Every pulse asserts exactly 1 cycle after the input change that caused it.
- Reset values: all outputs 0, byte_o=8'h00, state IDLE, shift register and counters 0.
  - Reset mid-frame discards the partial byte with no strobes.
  - The filter's post-reset 0 then 1 outputs must produce no START and no STOP.
- FSM states are IDLE, DATA and ACK.
  - IDLE: SCL edges still drive scl_rise_o/scl_fall_o, but no bits are sampled.
  - START from any state: go to DATA, bit_cnt=0, clear shift register, bus_busy_o=1, pulse start_o. Also pulse rep_start_o if bus_busy_o was already 1.
  - STOP from any state: go to IDLE, bus_busy_o=0, pulse stop_o. A partial byte is discarded (no byte_valid_o). A STOP during the ACK slot gives no ack_valid_o.
  - DATA, on SCL rise: shift sda_filt_i in at the LSB and increment bit_cnt.
  - DATA, on the 8th rise: load byte_o and pulse byte_valid_o in the same output cycle.
  - DATA, first SCL fall with bit_cnt=8: go to ACK and assert ack_slot_o.
  - ACK, on SCL rise: latch ack_bit_o and pulse ack_valid_o.
  - ACK, on SCL fall: deassert ack_slot_o, bit_cnt=0, return to DATA.
- Timeout counter:
  - Counts while bus_busy_o=1; cleared by any SCL edge, START or STOP.
  - On reaching TIMEOUT_CYC-1: pulse timeout_o, go to IDLE, bus_busy_o=0, no stop_o.
  - Counter saturates and never wraps.
  - Held at 0 when TIMEOUT_CYC=0.
- byte_o and ack_bit_o hold their value until the next update.

Decomposition:
- Shared I2C package/header i2c_defs holds:
  - state encodings (ST_IDLE, ST_DATA, ST_ACK);
  - I2C_BYTE_W=8 and I2C_ACK=1'b0;
  - the default timeout constant.
- One natural sub-module, i2c_bus_cond_detect: owns sda_q/scl_q and produces the START, STOP, SCL-rise and SCL-fall pulses. The FSM, shift register and timeout stay in the top.

Test Plan:
- Reset, then drive the 0->1 filter release on both lines -> no start_o, no stop_o; bus_busy_o=0; byte_o=8'h00.
- START, bits 0xA5 MSB-first, ACK low, STOP -> start_o once; byte_valid_o with byte_o=8'hA5 one cycle after the 8th rise; ack_slot_o spans the 8th to 9th fall; ack_valid_o with ack_bit_o=0; stop_o; bus_busy_o back to 0.
- START, byte 0x3C, ACK high (NACK), repeated START, byte 0xFF -> rep_start_o once; byte_o 8'h3C then 8'hFF; ack_bit_o=1; bus_busy_o stays 1 throughout.
- START, 5 bits, STOP -> no byte_valid_o; bit_cnt_o=0 after the stop; byte_o keeps its previous value.
- TIMEOUT_CYC=20: START, then hold SCL low -> timeout_o pulses exactly 20 cycles after the last SCL edge; bus_busy_o=0; no stop_o.
- SDA and SCL toggled in the same cycle, with rst_i asserted mid-byte -> no START or STOP detected; after reset all outputs 0 and no byte_valid_o.
